// File: rtl/pipe_mem_access.sv
`default_nettype none
// ============================================================================
// Module      : pipe_mem_access
// Description : MEM stage. It issues loads and stores over a req/ack bus and
//               stalls upstream until the bus responds. Optional bus timeout
//               is enabled by defining DMEM_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_mem_access #(
    parameter int          TIMEOUT_CYCLES = 16,
    parameter logic [31:0] ABORT_DATA     = 32'hDEADBEEF
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        mwreg,
    input  logic        mm2reg,
    input  logic        mwmem,
    input  logic [31:0] malu,
    input  logic [31:0] mb,
    input  logic [4:0]  mrn,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic        mem_stall,
    output logic        misalign,
`ifdef DMEM_TIMEOUT_EN
    output logic        timeout,
`endif
    output logic        wwreg,
    output logic        wm2reg,
    output logic [31:0] wmo,
    output logic [31:0] walu,
    output logic [4:0]  wrn
);

    localparam logic c_IDLE = 1'b0;
    localparam logic c_BUSY = 1'b1;

    logic        r_state;
    logic        w_next;
    logic        w_access;
    logic        w_aligned;
    logic        w_start;
    logic        w_misal;
    logic        w_abort;
    logic        r_l_wreg;
    logic        r_l_m2reg;
    logic [31:0] r_l_alu;
    logic [4:0]  r_l_rn;

    // A store takes priority when both mwmem and mm2reg are set.
    assign w_access  = mwmem | mm2reg;
    assign w_aligned = (malu[1:0] == 2'b00);
    assign w_start   = (r_state == c_IDLE) && w_access && w_aligned;
    assign w_misal   = (r_state == c_IDLE) && w_access && !w_aligned;

`ifdef DMEM_TIMEOUT_EN
    localparam int c_CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CW-1:0] c_TO_LAST = c_CW'(TIMEOUT_CYCLES - 1);

    logic [c_CW-1:0] r_to_cnt;

    assign w_abort = (r_state == c_BUSY) && !dm_ack && (r_to_cnt == c_TO_LAST);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_to_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            if (w_start)
                r_to_cnt <= '0;
            else if ((r_state == c_BUSY) && !dm_ack && !w_abort)
                r_to_cnt <= r_to_cnt + 1'b1;
            if (w_abort)
                timeout <= 1'b1;
        end
    end
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^(32'(TIMEOUT_CYCLES));
    assign w_abort      = 1'b0;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            r_state <= c_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (w_start) w_next = c_BUSY;
            c_BUSY:  if (dm_ack || w_abort) w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    always_comb begin
        mem_stall = 1'b0;
        dm_req    = 1'b0;
        case (r_state)
            c_IDLE:  mem_stall = w_start;
            c_BUSY: begin
                dm_req    = 1'b1;
                mem_stall = !dm_ack && !w_abort;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dm_we     <= 1'b0;
            dm_addr   <= '0;
            dm_wdata  <= '0;
            misalign  <= 1'b0;
            wwreg     <= 1'b0;
            wm2reg    <= 1'b0;
            wmo       <= '0;
            walu      <= '0;
            wrn       <= '0;
            r_l_wreg  <= 1'b0;
            r_l_m2reg <= 1'b0;
            r_l_alu   <= '0;
            r_l_rn    <= '0;
        end else if (w_start) begin
            dm_addr   <= {malu[31:2], 2'b00};
            dm_wdata  <= mb;
            dm_we     <= mwmem;
            r_l_wreg  <= mwreg;
            r_l_m2reg <= mm2reg;
            r_l_alu   <= malu;
            r_l_rn    <= mrn;
            wwreg     <= 1'b0;
            wm2reg    <= 1'b0;
        end else if (w_misal) begin
            misalign  <= 1'b1;
            wwreg     <= 1'b0;
            wm2reg    <= 1'b0;
        end else if (r_state == c_IDLE) begin
            wwreg     <= mwreg;
            wm2reg    <= 1'b0;
            wmo       <= '0;
            walu      <= malu;
            wrn       <= mrn;
        end else if (dm_ack || w_abort) begin
            // Stores never write back; a timed-out load returns ABORT_DATA.
            wwreg     <= r_l_wreg & ~dm_we;
            wm2reg    <= r_l_m2reg & ~dm_we;
            wmo       <= dm_we ? 32'd0 : (dm_ack ? dm_rdata : ABORT_DATA);
            walu      <= r_l_alu;
            wrn       <= r_l_rn;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_mem_access.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_mem_access
// Description : Randomized self-checking bench for pipe_mem_access.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_mem_access;

    logic        clock = 1'b0;
    logic        resetn;
    logic        mwreg, mm2reg, mwmem;
    logic [31:0] malu, mb;
    logic [4:0]  mrn;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic        mem_stall, misalign;
    logic        wwreg, wm2reg;
    logic [31:0] wmo, walu;
    logic [4:0]  wrn;

    int n_pass  = 0;
    int n_total = 0;

    // Expected architectural MEM/WB state.
    logic        e_wwreg, e_wm2reg, e_mis;
    logic [31:0] e_wmo, e_walu;
    logic [4:0]  e_wrn;

    always #5 clock = ~clock;

    pipe_mem_access dut (
        .clock     (clock),
        .resetn    (resetn),
        .mwreg     (mwreg),
        .mm2reg    (mm2reg),
        .mwmem     (mwmem),
        .malu      (malu),
        .mb        (mb),
        .mrn       (mrn),
        .dm_ack    (dm_ack),
        .dm_rdata  (dm_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .mem_stall (mem_stall),
        .misalign  (misalign),
        .wwreg     (wwreg),
        .wm2reg    (wm2reg),
        .wmo       (wmo),
        .walu      (walu),
        .wrn       (wrn)
    );

    task automatic model_reset();
        e_wwreg = 1'b0; e_wm2reg = 1'b0; e_mis = 1'b0;
        e_wmo = '0; e_walu = '0; e_wrn = '0;
    endtask

    // Presents one instruction at posedge+1, holds it while stalled, acts as the
    // memory (ack after 'delay' waiting BUSY cycles) and checks the outcome.
    task automatic run_instr(input logic wreg, input logic m2reg, input logic wmem,
                             input logic [31:0] alu, input logic [31:0] b,
                             input logic [4:0] rn, input int delay,
                             input logic [31:0] rdata);
        int   stalls;
        logic acc, is_store, aligned;
        mwreg = wreg; mm2reg = m2reg; mwmem = wmem;
        malu = alu; mb = b; mrn = rn;
        dm_ack = 1'($urandom_range(0, 1));
        dm_rdata = $urandom;
        acc = wmem | m2reg;
        is_store = wmem;
        aligned = (alu[1:0] == 2'b00);
        stalls = 0;
        #1;
        if (acc && aligned) begin
            n_total++;
            if ({mem_stall, dm_req} !== 2'b10) begin
                $display("FAIL idle_stall: got stall/req=%b want 10", {mem_stall, dm_req});
            end else n_pass++;
            stalls = 1;
            @(posedge clock); #1;
            for (int k = 0; k <= delay; k++) begin
                dm_ack   = (k == delay);
                dm_rdata = (k == delay) ? rdata : $urandom;
                #1;
                n_total++;
                if ({dm_req, dm_we, dm_addr, dm_wdata} !== {1'b1, is_store, alu[31:2], 2'b00, b}) begin
                    $display("FAIL bus: got req=%b we=%b addr=%h wdata=%h want req=1 we=%b addr=%h wdata=%h",
                             dm_req, dm_we, dm_addr, dm_wdata, is_store, {alu[31:2], 2'b00}, b);
                end else n_pass++;
                if (k == 0) begin
                    n_total++;
                    if ({wwreg, wm2reg} !== 2'b00) begin
                        $display("FAIL busy_bubble: got wwreg/wm2reg=%b want 00", {wwreg, wm2reg});
                    end else n_pass++;
                end
                if (mem_stall === 1'b1) stalls++;
                @(posedge clock); #1;
            end
            dm_ack = 1'b0;
            n_total++;
            if (stalls !== delay + 1) begin
                $display("FAIL stall_count: got %0d want %0d", stalls, delay + 1);
            end else n_pass++;
            e_wwreg  = wreg & ~is_store;
            e_wm2reg = m2reg & ~is_store;
            e_wmo    = is_store ? 32'd0 : rdata;
            e_walu   = alu;
            e_wrn    = rn;
        end else begin
            n_total++;
            if ({mem_stall, dm_req} !== 2'b00) begin
                $display("FAIL no_stall: got stall/req=%b want 00", {mem_stall, dm_req});
            end else n_pass++;
            @(posedge clock); #1;
            dm_ack = 1'b0;
            if (acc) begin
                e_wwreg = 1'b0; e_wm2reg = 1'b0; e_mis = 1'b1;
            end else begin
                e_wwreg = wreg; e_wm2reg = 1'b0; e_wmo = '0; e_walu = alu; e_wrn = rn;
            end
        end
        n_total++;
        if ({wwreg, wm2reg, wmo, walu, wrn} !== {e_wwreg, e_wm2reg, e_wmo, e_walu, e_wrn}) begin
            $display("FAIL wb: got wwreg=%b wm2reg=%b wmo=%h walu=%h wrn=%0d want %b %b %h %h %0d",
                     wwreg, wm2reg, wmo, walu, wrn, e_wwreg, e_wm2reg, e_wmo, e_walu, e_wrn);
        end else n_pass++;
        n_total++;
        if ({dm_req, misalign} !== {1'b0, e_mis}) begin
            $display("FAIL post_state: got req=%b misalign=%b want 0 %b", dm_req, misalign, e_mis);
        end else n_pass++;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        mwreg = 0; mm2reg = 0; mwmem = 0; malu = '0; mb = '0; mrn = '0;
        dm_ack = 0; dm_rdata = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        n_total++;
        if ({dm_req, dm_we, dm_addr, dm_wdata, misalign, mem_stall, wwreg, wm2reg, wmo, walu, wrn} !== '0) begin
            $display("FAIL reset: got req=%b we=%b addr=%h wdata=%h mis=%b stall=%b wb=%b%b %h %h %0d want all 0",
                     dm_req, dm_we, dm_addr, dm_wdata, misalign, mem_stall, wwreg, wm2reg, wmo, walu, wrn);
        end else n_pass++;
        resetn = 1'b1;
    endtask

    task automatic test_alu();
        run_instr(1'b1, 1'b0, 1'b0, 32'h1234, $urandom, 5'd5, 0, 32'd0);
    endtask

    task automatic test_load();
        run_instr(1'b1, 1'b1, 1'b0, 32'h40, $urandom, 5'd9, 2, 32'hCAFEF00D);
    endtask

    task automatic test_store();
        run_instr(1'b1, 1'b0, 1'b1, 32'h44, 32'hA5A5A5A5, 5'd3, 0, $urandom);
        run_instr(1'b1, 1'b1, 1'b1, 32'h48, 32'h0BADF00D, 5'd4, 1, $urandom);
    endtask

    task automatic test_misalign();
        run_instr(1'b1, 1'b1, 1'b0, 32'h43, $urandom, 5'd6, 0, 32'd0);
        run_instr(1'b1, 1'b1, 1'b0, 32'h50, $urandom, 5'd8, 1, 32'h13572468);
    endtask

    task automatic test_reset_busy();
        mwreg = 1; mm2reg = 1; mwmem = 0; malu = 32'h80; mb = '0; mrn = 5'd7;
        dm_ack = 0;
        @(posedge clock); #1;
        n_total++;
        if (dm_req !== 1'b1) begin
            $display("FAIL busy_entry: got req=%b want 1", dm_req);
        end else n_pass++;
        #2 resetn = 1'b0;
        #1;
        model_reset();
        n_total++;
        if ({dm_req, dm_we, dm_addr, dm_wdata, misalign, wwreg, wm2reg, wmo, walu, wrn} !== '0) begin
            $display("FAIL async_reset: got req=%b we=%b addr=%h wdata=%h mis=%b wb=%b%b %h %h %0d want all 0",
                     dm_req, dm_we, dm_addr, dm_wdata, misalign, wwreg, wm2reg, wmo, walu, wrn);
        end else n_pass++;
        mwreg = 0; mm2reg = 0; malu = '0; mrn = '0;
        @(posedge clock); #1;
        resetn = 1'b1;
        run_instr(1'b1, 1'b0, 1'b0, 32'h00C0FFEE, $urandom, 5'd12, 0, 32'd0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            int          kind;
            logic [31:0] a;
            kind = $urandom_range(0, 3);
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            case (kind)
                0: run_instr(1'($urandom), 1'b0, 1'b0, a, $urandom, 5'($urandom), 0, 32'd0);
                1: run_instr(1'($urandom), 1'b1, 1'b0, a, $urandom, 5'($urandom),
                             $urandom_range(0, 3), $urandom);
                2: run_instr(1'($urandom), 1'b0, 1'b1, a, $urandom, 5'($urandom),
                             $urandom_range(0, 3), $urandom);
                default: run_instr(1'($urandom), 1'b1, 1'b1, a, $urandom, 5'($urandom),
                                   $urandom_range(0, 3), $urandom);
            endcase
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_misalign();
        test_back_to_back();
        test_reset_busy();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
